multicycle_control: RTL and testbench

Moore control FSM for the 8-bit multicycle MIPS datapath. It sequences every instruction through fetch, decode, execute, memory and writeback, and drives all datapath enables and mux selects. Its PCEn output is the enable input of the program counter, and its PCSrc output selects the program counter's next-value source. It is the controlling end of the PC-enable interface.

---
 rtl/multicycle_control.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for the 8-bit multicycle MIPS datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath enable and mux select from the state register.
// Optional feature macro: CTRL_ADDI_EN adds the ADDIEX/ADDIWB states so that
// opcode 001000 runs as addi. Without it, that opcode is treated as illegal.
module multicycle_control (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] Op,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
`ifdef CTRL_ADDI_EN
        ST_JUMP   = 4'd10,
        ST_ADDIEX = 4'd11,
        ST_ADDIWB = 4'd12
`else
        ST_JUMP   = 4'd10
`endif
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

    state_t state_q;
    state_t state_d;

    // Internal-only controls; PCEn is formed from them.
    logic pc_write;
    logic branch;

    // State register: async active-low reset parks the FSM in RESET at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Op is only consulted in DECODE and MEMADR.
    always_comb begin
        state_d   = state_q;
        IllegalOp = 1'b0;
        case (state_q)
            ST_RESET:  state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYP:      state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
`ifdef CTRL_ADDI_EN
                    OP_ADDI:      state_d = ST_ADDIEX;
`endif
                    default: begin
                        // Unsupported opcode: flag it and abandon the instruction.
                        state_d   = ST_FETCH;
                        IllegalOp = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: state_d = (Op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  state_d = ST_MEMWB;
            ST_EXEC:   state_d = ST_ALUWB;
`ifdef CTRL_ADDI_EN
            ST_ADDIEX: state_d = ST_ADDIWB;
`endif
            // MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB and unused codes.
            default:   state_d = ST_FETCH;
        endcase
    end

    // Moore output decode; everything not named in a state stays 0.
    always_comb begin
        pc_write = 1'b0;
        branch   = 1'b0;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCSrc    = 2'b00;
        case (state_q)
            ST_FETCH: begin
                IRWrite  = 1'b1;
                pc_write = 1'b1;
                ALUSrcB  = 2'b01;
            end
            ST_DECODE: ALUSrcB = 2'b11;
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ST_MEMRD:  IorD = 1'b1;
            ST_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            ST_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            ST_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            ST_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
`ifdef CTRL_ADDI_EN
            ST_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ST_ADDIWB: RegWrite = 1'b1;
`endif
            default: ;
        endcase
    end

    // Zero only matters in BRANCH, where it gates the PC update.
    assign PCEn  = pc_write | (branch & Zero);
    assign State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control. Walks each instruction class
// through its state sequence with hand-computed expectations, including the
// asynchronous mid-instruction reset. Honours CTRL_ADDI_EN for the addi case.
module tb_multicycle_control;

    logic       clock;
    logic       reset_n;
    logic [5:0] Op;
    logic       Zero;
    logic       PCEn;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       IllegalOp;
    logic [3:0] State;

    int checks_total;
    int checks_passed;

    multicycle_control dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .Op        (Op),
        .Zero      (Zero),
        .PCEn      (PCEn),
        .IorD      (IorD),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .PCSrc     (PCSrc),
        .IllegalOp (IllegalOp),
        .State     (State)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks_total++;
        assert (obs === exp) begin
            checks_passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [14:0] all_outs;
    assign all_outs = {PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                       ALUSrcA, ALUSrcB, ALUOp, PCSrc, IllegalOp};

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset_n = 1'b0;
        Op      = 6'b000000;
        Zero    = 1'b0;

        // Reset held for 3 cycles
        tick(); tick(); tick();
        chk("reset_state", 16'(State), 16'd0);
        chk("reset_outs", 16'(all_outs), 16'd0);
        reset_n = 1'b1;
        tick();
        chk("fetch_state", 16'(State), 16'd1);
        chk("fetch_pcen", 16'(PCEn), 16'd1);
        chk("fetch_irwrite", 16'(IRWrite), 16'd1);
        chk("fetch_alusrcb", 16'(ALUSrcB), 16'd1);
        $display("txn reset/first fetch done");

        // lw
        Op = 6'b100011;
        tick(); chk("lw_s2", 16'(State), 16'd2);
        chk("lw_decode_alusrcb", 16'(ALUSrcB), 16'd3);
        chk("lw_decode_pcen", 16'(PCEn), 16'd0);
        tick(); chk("lw_s3", 16'(State), 16'd3);
        chk("lw_memadr_srcs", 16'({ALUSrcA, ALUSrcB}), 16'b110);
        tick(); chk("lw_s4", 16'(State), 16'd4);
        chk("lw_memrd_iord", 16'(IorD), 16'd1);
        chk("lw_memrd_regwrite", 16'({RegWrite, MemtoReg}), 16'd0);
        tick(); chk("lw_s5", 16'(State), 16'd5);
        chk("lw_memwb_wr", 16'({RegWrite, MemtoReg, IorD}), 16'b110);
        tick(); chk("lw_back_fetch", 16'(State), 16'd1);
        chk("lw_fetch_regwrite", 16'(RegWrite), 16'd0);
        $display("txn lw done");

        // sw
        Op = 6'b101011;
        tick(); chk("sw_s2", 16'(State), 16'd2);
        tick(); chk("sw_s3", 16'(State), 16'd3);
        chk("sw_memadr_memwrite", 16'(MemWrite), 16'd0);
        tick(); chk("sw_s6", 16'(State), 16'd6);
        chk("sw_memwr_strobes", 16'({IorD, MemWrite}), 16'b11);
        tick(); chk("sw_back_fetch", 16'(State), 16'd1);
        chk("sw_fetch_memwrite", 16'(MemWrite), 16'd0);
        $display("txn sw done");

        // R-type
        Op = 6'b000000;
        tick(); chk("r_s2", 16'(State), 16'd2);
        tick(); chk("r_s7", 16'(State), 16'd7);
        chk("r_exec_aluop", 16'({ALUSrcA, ALUOp}), 16'b110);
        tick(); chk("r_s8", 16'(State), 16'd8);
        chk("r_aluwb_wr", 16'({RegDst, RegWrite, MemtoReg}), 16'b110);
        tick(); chk("r_back_fetch", 16'(State), 16'd1);
        $display("txn rtype done");

        // beq, Zero = 0
        Op = 6'b000100; Zero = 1'b0;
        tick(); chk("beq0_s2", 16'(State), 16'd2);
        tick(); chk("beq0_s9", 16'(State), 16'd9);
        chk("beq0_pcen", 16'(PCEn), 16'd0);
        chk("beq0_pcsrc", 16'({PCSrc, ALUOp}), 16'b0101);
        tick(); chk("beq0_back_fetch", 16'(State), 16'd1);
        $display("txn beq zero=0 done");

        // beq, Zero = 1, plus combinational dependence on Zero
        Zero = 1'b1;
        tick(); chk("beq1_s2", 16'(State), 16'd2);
        chk("beq1_decode_pcen", 16'(PCEn), 16'd0);
        tick(); chk("beq1_s9", 16'(State), 16'd9);
        chk("beq1_pcen", 16'(PCEn), 16'd1);
        chk("beq1_pcsrc", 16'(PCSrc), 16'd1);
        Zero = 1'b0; #1;
        chk("beq1_zero_drop_pcen", 16'(PCEn), 16'd0);
        Zero = 1'b1;
        tick(); chk("beq1_back_fetch", 16'(State), 16'd1);
        Zero = 1'b0;
        $display("txn beq zero=1 done");

        // j
        Op = 6'b000010;
        tick(); chk("j_s2", 16'(State), 16'd2);
        tick(); chk("j_s10", 16'(State), 16'd10);
        chk("j_pcen_pcsrc", 16'({PCEn, PCSrc}), 16'b110);
        tick(); chk("j_back_fetch", 16'(State), 16'd1);
        $display("txn j done");

        // illegal opcode
        Op = 6'b111111;
        chk("ill_fetch_flag", 16'(IllegalOp), 16'd0);
        tick(); chk("ill_s2", 16'(State), 16'd2);
        chk("ill_flag", 16'(IllegalOp), 16'd1);
        tick(); chk("ill_back_fetch", 16'(State), 16'd1);
        chk("ill_flag_clear", 16'(IllegalOp), 16'd0);
        $display("txn illegal done");

        // addi
        Op = 6'b001000;
        tick(); chk("addi_s2", 16'(State), 16'd2);
`ifdef CTRL_ADDI_EN
        chk("addi_flag", 16'(IllegalOp), 16'd0);
        tick(); chk("addi_s11", 16'(State), 16'd11);
        chk("addi_ex_srcs", 16'({ALUSrcA, ALUSrcB}), 16'b110);
        tick(); chk("addi_s12", 16'(State), 16'd12);
        chk("addi_wb_regwrite", 16'({RegWrite, RegDst}), 16'b10);
`else
        chk("addi_illegal_flag", 16'(IllegalOp), 16'd1);
`endif
        tick(); chk("addi_back_fetch", 16'(State), 16'd1);
        $display("txn addi done");

        // mid-instruction asynchronous reset while in MEMWR
        Op = 6'b101011;
        tick(); tick(); tick();
        chk("mid_s6", 16'(State), 16'd6);
        chk("mid_memwrite_hi", 16'(MemWrite), 16'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_async_state", 16'(State), 16'd0);
        chk("mid_async_memwrite", 16'(MemWrite), 16'd0);
        chk("mid_async_outs", 16'(all_outs), 16'd0);
        tick();
        chk("mid_held_state", 16'(State), 16'd0);
        reset_n = 1'b1;
        tick();
        chk("mid_release_fetch", 16'(State), 16'd1);
        $display("txn mid-instruction reset done");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
